wb_arbiter: RTL and testbench

- Write-side initiator for the CPU register file write port (w_en / rd_addr / rd_write_data).
- Collects writeback results from two producers: the ALU path and the load (mem) path.
- Each producer uses a valid/ready handshake into its own small FIFO.
- Arbitrates the FIFOs onto the single register-file write port as one registered write per cycle, and drops writes to x0.

---
 rtl/wb_arbiter_pkg.sv | 29 ++
 rtl/wb_fifo.sv | 64 ++++++
 rtl/wb_arbiter.sv | 141 ++++++++++++++
 tb/tb_wb_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: register-file widths,
// grant encoding and the channel-select decision.
package wb_arbiter_pkg;

    // Default register-file geometry, shared with register_file.
    localparam int RF_ADDR_LEN_DEFAULT = 5;
    localparam int RF_DATA_LEN_DEFAULT = 32;

    // Grant encoding for the single register-file write port.
    typedef enum logic [1:0] {
        WB_SEL_NONE = 2'd0,
        WB_SEL_ALU  = 2'd1,
        WB_SEL_MEM  = 2'd2
    } wb_sel_e;

    // Mem normally wins a collision; alu_forced overrides that when the ALU
    // has waited too long behind a continuous load stream.
    function automatic wb_sel_e wb_select(input logic alu_pending,
                                          input logic mem_pending,
                                          input logic alu_forced);
        if (alu_pending && (alu_forced || !mem_pending)) begin
            return WB_SEL_ALU;
        end else if (mem_pending) begin
            return WB_SEL_MEM;
        end
        return WB_SEL_NONE;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO used as the per-producer writeback buffer.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module wb_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = storage[rd_ptr];

    // Entry storage, written at the tail on an accepted push.
    // NOTE: the data array is deliberately not reset; count gates every
    // read, so stale contents are never observed and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
    // NOTE: state updates use <= so every register samples pre-edge values,
    // independent of statement order inside the block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers ALU and load results in per-channel FIFOs and
// issues at most one registered register-file write per cycle. Writes to x0
// are accepted but discarded. Optional anti-starvation for the ALU channel
// is enabled with macro WB_FAIRNESS_EN (default build: strict mem priority).
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int RF_ADDR_LEN  = RF_ADDR_LEN_DEFAULT,
    parameter int RF_DATA_LEN  = RF_DATA_LEN_DEFAULT,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [RF_ADDR_LEN-1:0] alu_rd_addr,
    input  logic [RF_DATA_LEN-1:0] alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [RF_ADDR_LEN-1:0] mem_rd_addr,
    input  logic [RF_DATA_LEN-1:0] mem_data,
    output logic                   rf_w_en,
    output logic [RF_ADDR_LEN-1:0] rf_rd_addr,
    output logic [RF_DATA_LEN-1:0] rf_rd_write_data,
    output logic                   idle
);

    localparam int ENTRY_W = RF_ADDR_LEN + RF_DATA_LEN;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    // Elaboration-time guards on the configuration.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wb_arbiter: FIFO_DEPTH must be a power of two >= 2");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("wb_arbiter: STARVE_LIMIT must be >= 1");
    end

    logic               alu_push, mem_push;
    logic               alu_pop, mem_pop;
    logic               alu_full, mem_full;
    logic               alu_empty, mem_empty;
    logic [CNT_W-1:0]   alu_count, mem_count;
    logic [ENTRY_W-1:0] alu_head, mem_head;
    logic               alu_forced;
    wb_sel_e            grant;

    // Ready depends only on registered occupancy, never on valid, and is
    // held low for the whole time reset is asserted.
    assign alu_ready = rst && !alu_full;
    assign mem_ready = rst && !mem_full;

    // A handshake to x0 completes but never enters the FIFO.
    assign alu_push = alu_valid && alu_ready && (alu_rd_addr != '0);
    assign mem_push = mem_valid && mem_ready && (mem_rd_addr != '0);

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (alu_push),
        .wdata ({alu_rd_addr, alu_data}),
        .pop   (alu_pop),
        .rdata (alu_head),
        .full  (alu_full),
        .empty (alu_empty),
        .count (alu_count)
    );

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_mem_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (mem_push),
        .wdata ({mem_rd_addr, mem_data}),
        .pop   (mem_pop),
        .rdata (mem_head),
        .full  (mem_full),
        .empty (mem_empty),
        .count (mem_count)
    );

`ifdef WB_FAIRNESS_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_cnt;

    assign alu_forced = (starve_cnt == STARVE_W'(STARVE_LIMIT));

    // Count mem grants that bypass a waiting ALU entry; reset on any ALU grant or an empty ALU FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (alu_empty || grant == WB_SEL_ALU) begin
            starve_cnt <= '0;
        end else if (grant == WB_SEL_MEM) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end
`else
    assign alu_forced = 1'b0;
`endif

    // Channel select from FIFO state only; the granted head is popped at the edge.
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        alu_pop = 1'b0;
        mem_pop = 1'b0;
        grant   = wb_select(!alu_empty, !mem_empty, alu_forced);
        case (grant)
            WB_SEL_ALU: alu_pop = 1'b1;
            WB_SEL_MEM: mem_pop = 1'b1;
            default:    ;
        endcase
    end

    // Output register: one write strobe per popped entry; addr/data hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_w_en          <= 1'b0;
            rf_rd_addr       <= '0;
            rf_rd_write_data <= '0;
        end else begin
            rf_w_en <= (grant != WB_SEL_NONE);
            case (grant)
                WB_SEL_ALU: {rf_rd_addr, rf_rd_write_data} <= alu_head;
                WB_SEL_MEM: {rf_rd_addr, rf_rd_write_data} <= mem_head;
                default:    ;
            endcase
        end
    end

    assign idle = (alu_count == '0) && (mem_count == '0) && !rf_w_en;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: expected writes are queued as stimulus
// is driven and compared as rf_w_en pulses appear. Fairness expectations
// follow the WB_FAIRNESS_EN macro of the build.
module tb_wb_arbiter;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    localparam int STOP_ITER = 20;

    logic        clk;
    logic        rst;
    logic        alu_valid, mem_valid;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_rd_addr, mem_rd_addr;
    logic [31:0] alu_data, mem_data;
    logic        rf_w_en;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_write_data;
    logic        idle;

    wr_t sb_q[$];
    bit  sb_on;
    int  n_checks;
    int  n_fail;

    wb_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .alu_valid        (alu_valid),
        .alu_ready        (alu_ready),
        .alu_rd_addr      (alu_rd_addr),
        .alu_data         (alu_data),
        .mem_valid        (mem_valid),
        .mem_ready        (mem_ready),
        .mem_rd_addr      (mem_rd_addr),
        .mem_data         (mem_data),
        .rf_w_en          (rf_w_en),
        .rf_rd_addr       (rf_rd_addr),
        .rf_rd_write_data (rf_rd_write_data),
        .idle             (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (sb_on && rf_w_en) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", rf_w_en, 1'b0);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("wr_addr", rf_rd_addr, e.addr);
                check("wr_data", rf_rd_write_data, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_alu(input logic [4:0] a, input logic [31:0] d);
        int n;
        alu_valid = 1'b1; alu_rd_addr = a; alu_data = d; n = 0;
        do begin @(negedge clk); n++; end while (!alu_ready && n < 50);
        if (!alu_ready) check("alu_push_timeout", alu_ready, 1'b1);
        step();
    endtask

    task automatic push_mem(input logic [4:0] a, input logic [31:0] d);
        int n;
        mem_valid = 1'b1; mem_rd_addr = a; mem_data = d; n = 0;
        do begin @(negedge clk); n++; end while (!mem_ready && n < 50);
        if (!mem_ready) check("mem_push_timeout", mem_ready, 1'b1);
        step();
    endtask

    task automatic drain(input string tag);
        repeat (6) @(negedge clk);
        check({tag, "_sb_drained"}, sb_q.size(), 0);
        check({tag, "_idle"}, idle, 1'b1);
        step();
    endtask

    initial begin
        bit alu_seen;
        int alu_iter, acc_iter, mem_after, alu_mem_before, k, n;
        bit m_go, a_go;

        n_checks = 0; n_fail = 0; sb_on = 1'b1;
        rst = 1'b0;
        alu_valid = 1'b0; alu_rd_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd_addr = '0; mem_data = '0;

        // Reset state.
        #1;
        check("rst_w_en", rf_w_en, 1'b0);
        check("rst_addr", rf_rd_addr, 5'd0);
        check("rst_data", rf_rd_write_data, 32'd0);
        check("rst_alu_ready", alu_ready, 1'b0);
        check("rst_mem_ready", mem_ready, 1'b0);
        check("rst_idle", idle, 1'b1);
        #11 rst = 1'b1;
        step();
        check("post_rst_alu_ready", alu_ready, 1'b1);
        check("post_rst_mem_ready", mem_ready, 1'b1);

        // Single write and its latency.
        sb_q.push_back('{addr: 5'd8, data: 32'd24});
        push_alu(5'd8, 32'd24);
        alu_valid = 1'b0;
        @(negedge clk); check("single_not_bypassed", rf_w_en, 1'b0);
        @(negedge clk); check("single_w_en", rf_w_en, 1'b1);
        check("single_addr", rf_rd_addr, 5'd8);
        check("single_data", rf_rd_write_data, 32'd24);
        @(negedge clk); check("single_one_cycle", rf_w_en, 1'b0);
        step();

        // x0 filter, then a real write.
        push_alu(5'd0, 32'd3);
        alu_valid = 1'b0;
        repeat (4) begin @(negedge clk); check("x0_no_write", rf_w_en, 1'b0); end
        step();
        sb_q.push_back('{addr: 5'd10, data: 32'd30});
        push_alu(5'd10, 32'd30);
        alu_valid = 1'b0;
        drain("x0");

        // Collision: mem wins, ALU follows next cycle.
        sb_q.push_back('{addr: 5'd1, data: 32'd3});
        sb_q.push_back('{addr: 5'd9, data: 32'd27});
        mem_valid = 1'b1; mem_rd_addr = 5'd1; mem_data = 32'd3;
        alu_valid = 1'b1; alu_rd_addr = 5'd9; alu_data = 32'd27;
        n = 0;
        do begin @(negedge clk); n++; end while (!(alu_ready && mem_ready) && n < 50);
        check("collision_ready", alu_ready && mem_ready, 1'b1);
        step();
        mem_valid = 1'b0; alu_valid = 1'b0;
        drain("collision");

        // Ordering of back-to-back mem pushes.
        sb_q.push_back('{addr: 5'd2, data: 32'd5});
        sb_q.push_back('{addr: 5'd3, data: 32'd6});
        sb_q.push_back('{addr: 5'd4, data: 32'd7});
        push_mem(5'd2, 32'd5);
        push_mem(5'd3, 32'd6);
        push_mem(5'd4, 32'd7);
        mem_valid = 1'b0;
        drain("ordering");

        // Fill ALU FIFO behind a mem stream, then reset mid-stream.
        sb_on = 1'b0;
        mem_valid = 1'b1; mem_rd_addr = 5'd20; mem_data = 32'd200;
        step(); step();
        push_alu(5'd11, 32'd1);
        push_alu(5'd12, 32'd2);
        alu_rd_addr = 5'd13; alu_data = 32'd3;
        @(negedge clk);
        check("alu_full_not_ready", alu_ready, 1'b0);
        check("mem_stream_ready", mem_ready, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("midrst_w_en", rf_w_en, 1'b0);
        check("midrst_addr", rf_rd_addr, 5'd0);
        check("midrst_data", rf_rd_write_data, 32'd0);
        check("midrst_alu_ready", alu_ready, 1'b0);
        check("midrst_mem_ready", mem_ready, 1'b0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        sb_on = 1'b1;
        repeat (6) begin @(negedge clk); check("reset_no_stale_write", rf_w_en, 1'b0); end
        check("reset_idle", idle, 1'b1);
        step();

        // Fairness: continuous mem stream with one ALU entry.
        sb_on = 1'b0;
        alu_seen = 1'b0; alu_iter = -1; acc_iter = -1; mem_after = 0; alu_mem_before = -1; k = 0;
        mem_valid = 1'b1; mem_rd_addr = 5'd16; mem_data = 32'd100;
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(negedge clk);
            if (rf_w_en) begin
                if (rf_rd_addr == 5'd9 && !alu_seen) begin
                    alu_seen = 1'b1; alu_iter = cyc; alu_mem_before = mem_after;
                end else if (acc_iter >= 0 && cyc >= acc_iter + 2 && !alu_seen) begin
                    mem_after++;
                end
            end
            m_go = mem_valid && mem_ready;
            a_go = alu_valid && alu_ready;
            step();
            if (m_go) begin
                k++;
                mem_rd_addr = 5'(16 + (k % 15));
                mem_data = 32'(100 + k);
            end
            if (cyc == STOP_ITER) mem_valid = 1'b0;
            if (a_go) begin alu_valid = 1'b0; acc_iter = cyc; end
            if (cyc == 3) begin alu_valid = 1'b1; alu_rd_addr = 5'd9; alu_data = 32'd27; end
        end
        mem_valid = 1'b0; alu_valid = 1'b0;
        check("fair_alu_written", alu_seen, 1'b1);
`ifdef WB_FAIRNESS_EN
        check("fair_mem_before_alu", alu_mem_before, 4);
`else
        check("nofair_alu_after_mem_stop", (alu_iter > STOP_ITER), 1'b1);
`endif
        repeat (6) @(negedge clk);
        check("fair_idle", idle, 1'b1);
        sb_on = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
